// File: rtl/mult4x4_dot_acc_pkg.sv
// Shared types and default widths for the dot-product accumulator that sits
// behind the 4x4 array multiplier.
package mult4x4_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PROD_W = 8;
  localparam int ACC_W  = 12;

endpackage

// File: rtl/mult4x4_dot_acc_if.sv
// Product-in / result-out stream bundle. The accumulator is the slave; the
// producer/consumer pair drives it through the master modport.
interface mult4x4_dot_acc_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12,
  parameter int LEN_W  = 5
);

  logic [PROD_W-1:0] in_product;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [LEN_W-1:0]  out_len;
  logic              out_ovf;
  logic              out_trunc;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_product, in_valid, in_last, out_ready,
    input  in_ready, out_sum, out_len, out_ovf, out_trunc, out_valid
  );

  modport slave (
    input  in_product, in_valid, in_last, out_ready,
    output in_ready, out_sum, out_len, out_ovf, out_trunc, out_valid
  );

endinterface

// File: rtl/mult4x4_dot_acc_sat_add.sv
// Combinational unsigned adder that clamps at the all-ones accumulator value
// and flags when the clamp engaged.
module mult4x4_sat_add #(
  parameter int ACC_W  = 12,
  parameter int PROD_W = 8
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              sat
);

  // One spare bit catches the carry-out; the product is zero-extended.
  logic [ACC_W:0] full;

  assign full = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
  assign sat  = full[ACC_W];
  assign sum  = sat ? {ACC_W{1'b1}} : full[ACC_W-1:0];

endmodule

// File: rtl/mult4x4_dot_acc.sv
// Accumulates a stream of products into a saturated dot-product sum and holds
// each closed vector on a valid/ready result port until it is taken.
module mult4x4_dot_acc #(
  parameter int PROD_W  = mult4x4_acc_pkg::PROD_W,
  parameter int MAX_LEN = 16,
  parameter int ACC_W   = mult4x4_acc_pkg::ACC_W,
  parameter int LEN_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  mult4x4_dot_acc_if.slave bus
);

  import mult4x4_acc_pkg::*;

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [LEN_W-1:0]   cnt_reg, cnt_next;
  logic               ovf_reg, ovf_next;
  logic               trunc_reg, trunc_next;

  logic               done;
  logic               accept;
  logic [ACC_W-1:0]   add_a;
  logic [ACC_W-1:0]   add_sum;
  logic               add_sat;
  logic [LEN_W-1:0]   cnt_base;
  logic [LEN_W-1:0]   cnt_inc;
  logic               len_hit;

  assign done   = (state_reg == DONE);
  assign accept = bus.in_valid & ~done;

  // A fresh vector adds onto zero, so IDLE and ACC share one adder and one
  // incrementer; the first beat can never saturate since ACC_W >= PROD_W.
  assign add_a    = (state_reg == ACC) ? acc_reg : '0;
  assign cnt_base = (state_reg == ACC) ? cnt_reg : '0;
  assign cnt_inc  = cnt_base + LEN_W'(1);
  assign len_hit  = (cnt_inc == LEN_W'(MAX_LEN));

  mult4x4_sat_add #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_add (
    .a   (add_a),
    .b   (bus.in_product),
    .sum (add_sum),
    .sat (add_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      trunc_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
      trunc_reg <= trunc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    trunc_next = trunc_reg;
    case (state_reg)
      IDLE, ACC: begin
        if (accept) begin
          acc_next = add_sum;
          cnt_next = cnt_inc;
          ovf_next = ((state_reg == ACC) & ovf_reg) | add_sat;
          if (bus.in_last || len_hit) begin
            state_next = DONE;
            trunc_next = ~bus.in_last;
          end else begin
            state_next = ACC;
            trunc_next = 1'b0;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
          acc_next   = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
          trunc_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        acc_next   = '0;
        cnt_next   = '0;
        ovf_next   = 1'b0;
        trunc_next = 1'b0;
      end
    endcase
  end

  // Result fields come straight from registers and read as zero outside DONE.
  genvar gi;
  generate
    for (gi = 0; gi < ACC_W; gi++) begin : g_sum
      assign bus.out_sum[gi] = acc_reg[gi] & done;
    end
    for (gi = 0; gi < LEN_W; gi++) begin : g_len
      assign bus.out_len[gi] = cnt_reg[gi] & done;
    end
  endgenerate

  assign bus.out_ovf   = ovf_reg & done;
  assign bus.out_trunc = trunc_reg & done;
  assign bus.out_valid = done;
  assign bus.in_ready  = ~done;

endmodule

// File: tb/tb_mult4x4_dot_acc.sv
// Bench for mult4x4_dot_acc: directed vector table and corner sequences on a
// 12-bit instance, saturation and a random run against a vector model on a
// 10-bit instance.
module tb_mult4x4_dot_acc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       sel;
  logic [7:0] d_product;
  logic       d_valid, d_last, d_oready;

  mult4x4_dot_acc_if #(.PROD_W(8), .ACC_W(12), .LEN_W(5)) ifa ();
  mult4x4_dot_acc_if #(.PROD_W(8), .ACC_W(10), .LEN_W(5)) ifb ();

  assign ifa.in_product = d_product;
  assign ifa.in_last    = d_last;
  assign ifa.in_valid   = d_valid & ~sel;
  assign ifa.out_ready  = d_oready & ~sel;
  assign ifb.in_product = d_product;
  assign ifb.in_last    = d_last;
  assign ifb.in_valid   = d_valid & sel;
  assign ifb.out_ready  = d_oready & sel;

  mult4x4_dot_acc #(.PROD_W(8), .MAX_LEN(16), .ACC_W(12), .LEN_W(5)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa.slave)
  );
  mult4x4_dot_acc #(.PROD_W(8), .MAX_LEN(16), .ACC_W(10), .LEN_W(5)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb.slave)
  );

  int m_sum, m_len, m_ovf, m_trunc, m_valid, m_ready;
  always_comb begin
    m_sum   = sel ? int'(ifb.out_sum)   : int'(ifa.out_sum);
    m_len   = sel ? int'(ifb.out_len)   : int'(ifa.out_len);
    m_ovf   = sel ? int'(ifb.out_ovf)   : int'(ifa.out_ovf);
    m_trunc = sel ? int'(ifb.out_trunc) : int'(ifa.out_trunc);
    m_valid = sel ? int'(ifb.out_valid) : int'(ifa.out_valid);
    m_ready = sel ? int'(ifb.in_ready)  : int'(ifa.in_ready);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " out_valid"}, m_valid, 0);
    chk({tag, " in_ready"},  m_ready, 1);
    chk({tag, " out_sum"},   m_sum,   0);
    chk({tag, " out_len"},   m_len,   0);
    chk({tag, " out_ovf"},   m_ovf,   0);
    chk({tag, " out_trunc"}, m_trunc, 0);
  endtask

  // n beats of value v, in_last on the final one when lastf; one beat per cycle.
  task automatic send_vec(input string tag, input int n, input int v, input bit lastf);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, " in_ready during beat"}, m_ready, 1);
      d_valid   = 1'b1;
      d_product = 8'(v);
      d_last    = lastf && (i == n - 1);
    end
  endtask

  // Called at the first negedge after the closing beat: result must already be up.
  task automatic check_result(input string tag, input int es, input int el,
                              input int eo, input int et);
    chk({tag, " out_valid"}, m_valid, 1);
    chk({tag, " in_ready"},  m_ready, 0);
    chk({tag, " out_sum"},   m_sum,   es);
    chk({tag, " out_len"},   m_len,   el);
    chk({tag, " out_ovf"},   m_ovf,   eo);
    chk({tag, " out_trunc"}, m_trunc, et);
    $display("%s: sum=%0d len=%0d ovf=%0d trunc=%0d", tag, m_sum, m_len, m_ovf, m_trunc);
  endtask

  task automatic finish_vec(input string tag, input int es, input int el,
                            input int eo, input int et);
    @(negedge clk);
    d_valid = 1'b0;
    d_last  = 1'b0;
    check_result(tag, es, el, eo, et);
    d_oready = 1'b1;
    @(negedge clk);
    d_oready = 1'b0;
    check_idle({tag, " after take"});
  endtask

  typedef struct {
    string name;
    int    n;
    int    val;
    bit    lastf;
    int    exp_sum;
    int    exp_len;
    int    exp_ovf;
    int    exp_trunc;
  } vec_t;

  typedef struct {
    int sum;
    int len;
    int ovf;
    int trunc;
  } res_t;

  vec_t vecs[6];

  res_t exp_q[$];
  int   cur_sum, cur_len, nvec;
  bit   pending;

  initial begin
    vecs[0] = '{"four_225_last",   4, 225, 1'b1,  900,  4, 0, 0};
    vecs[1] = '{"sixteen_225",    16, 225, 1'b0, 3600, 16, 0, 1};
    vecs[2] = '{"beat17_new_vec",  1,   7, 1'b1,    7,  1, 0, 0};
    vecs[3] = '{"last_at_max",    16, 255, 1'b1, 4080, 16, 0, 0};
    vecs[4] = '{"single_zero",     1,   0, 1'b1,    0,  1, 0, 0};
    vecs[5] = '{"three_10",        3,  10, 1'b1,   30,  3, 0, 0};

    sel = 1'b0; rst = 1'b1;
    d_valid = 1'b1; d_product = 8'd200; d_last = 1'b1; d_oready = 1'b0;

    // Reset held for two edges with a beat offered.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    d_valid = 1'b0;
    d_last  = 1'b0;
    check_idle("reset");
    send_vec("post_reset", 1, 3, 1'b1);
    finish_vec("post_reset", 3, 1, 0, 0);

    foreach (vecs[i]) begin
      send_vec(vecs[i].name, vecs[i].n, vecs[i].val, vecs[i].lastf);
      finish_vec(vecs[i].name, vecs[i].exp_sum, vecs[i].exp_len,
                 vecs[i].exp_ovf, vecs[i].exp_trunc);
    end

    // Back-pressure in DONE with a beat waiting.
    send_vec("hold", 3, 20, 1'b1);
    @(negedge clk);
    d_valid = 1'b1; d_product = 8'd5; d_last = 1'b1; d_oready = 1'b0;
    check_result("hold", 60, 3, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold out_valid", m_valid, 1);
      chk("hold in_ready",  m_ready, 0);
      chk("hold out_sum",   m_sum,   60);
      chk("hold out_len",   m_len,   3);
    end
    d_oready = 1'b1;
    @(negedge clk);
    d_oready = 1'b0;
    chk("hold released out_valid", m_valid, 0);
    chk("hold released in_ready",  m_ready, 1);
    finish_vec("pending_beat", 5, 1, 0, 0);

    // Reset in the middle of a vector.
    send_vec("partial", 1, 100, 1'b0);
    send_vec("partial", 1, 50, 1'b0);
    @(negedge clk);
    d_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("mid_reset");
    send_vec("after_mid_reset", 1, 9, 1'b1);
    finish_vec("after_mid_reset", 9, 1, 0, 0);

    // Narrow accumulator: saturation and sticky-flag clearing.
    sel = 1'b1;
    @(negedge clk);
    check_idle("b idle");
    send_vec("sat_five_225", 5, 225, 1'b1);
    finish_vec("sat_five_225", 1023, 5, 1, 0);
    send_vec("after_sat", 1, 9, 1'b1);
    finish_vec("after_sat", 9, 1, 0, 0);

    // Random traffic against a vector-level model of the narrow instance.
    cur_sum = 0; cur_len = 0; pending = 1'b0; nvec = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (pending) begin
        chk("rand out_valid", m_valid, 1);
        chk("rand in_ready",  m_ready, 0);
        chk("rand out_sum",   m_sum,   exp_q[0].sum);
        chk("rand out_len",   m_len,   exp_q[0].len);
        chk("rand out_ovf",   m_ovf,   exp_q[0].ovf);
        chk("rand out_trunc", m_trunc, exp_q[0].trunc);
      end else begin
        chk("rand out_valid", m_valid, 0);
        chk("rand in_ready",  m_ready, 1);
      end
      d_valid   = ($urandom_range(3) != 0);
      d_last    = ($urandom_range(4) == 0);
      d_oready  = ($urandom_range(1) == 1);
      d_product = ($urandom_range(1) == 1) ? 8'd225 : 8'($urandom_range(255));
      if (pending && d_oready) begin
        nvec++;
        $display("rand vec %0d: sum=%0d len=%0d ovf=%0d trunc=%0d",
                 nvec, exp_q[0].sum, exp_q[0].len, exp_q[0].ovf, exp_q[0].trunc);
        void'(exp_q.pop_front());
        pending = 1'b0;
      end else if (!pending && d_valid) begin
        cur_sum += int'(d_product);
        cur_len++;
        if (d_last || cur_len == 16) begin
          exp_q.push_back('{(cur_sum > 1023) ? 1023 : cur_sum, cur_len,
                            (cur_sum > 1023) ? 1 : 0, d_last ? 0 : 1});
          pending = 1'b1;
          cur_sum = 0;
          cur_len = 0;
        end
      end
    end
    @(negedge clk);
    d_valid = 1'b0;
    d_oready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
